// File: rtl/inst_fetcher.sv
// Instruction fetch stage: looks up the icache, falls back to memory on a miss, issues words to the queue.
// Define IFETCH_ICACHE_EN to enable the icache lookup/fill path; without it every fetch goes to memory.
module inst_fetcher #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clr_in,
  input  logic [31:0] clr_pc,
  output logic [31:0] if_to_ic_inst_addr,
  output logic [31:0] if_to_ic_inst,
  output logic        if_to_ic_inst_valid,
  output logic        if_to_ic_ready,
  input  logic        ic_to_if_hit,
  input  logic [31:0] ic_to_if_hit_inst,
  output logic        if_to_mc_req,
  output logic [31:0] if_to_mc_addr,
  input  logic        mc_to_if_done,
  input  logic [31:0] mc_to_if_inst,
  output logic        if_to_iq_valid,
  output logic [31:0] if_to_iq_inst,
  output logic [31:0] if_to_iq_pc,
  input  logic        iq_to_if_full
);

`ifdef IFETCH_ICACHE_EN
  typedef enum logic [1:0] {LOOKUP = 2'd0, MEM_WAIT = 2'd1, FILL = 2'd2} state_t;
`else
  typedef enum logic [1:0] {LOOKUP = 2'd0, MEM_WAIT = 2'd1} state_t;
`endif

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_pc;
  logic [31:0] r_mc_addr;
  logic        r_mc_req;
  logic        r_iq_valid;
  logic [31:0] r_iq_inst;
  logic [31:0] r_iq_pc;
  logic [31:0] r_ic_inst;
  logic        w_lookup_go;
  logic        w_hit;
  logic        w_hit_go;
  logic        w_miss_go;
  logic        w_done_go;

  // A lookup only starts when the queue can take an entry and no redirect is pending.
  assign w_lookup_go = (r_state == LOOKUP) && rdy_in && !iq_to_if_full && !clr_in;

`ifdef IFETCH_ICACHE_EN
  logic r_ic_valid;
  assign w_hit               = ic_to_if_hit;
  assign if_to_ic_ready      = w_lookup_go;
  assign if_to_ic_inst_valid = r_ic_valid && rdy_in && !clr_in;
`else
  logic w_unused_hit;
  assign w_unused_hit        = ic_to_if_hit;
  assign w_hit               = 1'b0;
  assign if_to_ic_ready      = 1'b0;
  assign if_to_ic_inst_valid = 1'b0;
`endif

  assign if_to_ic_inst_addr = (r_state == LOOKUP) ? r_pc : r_mc_addr;
  assign if_to_ic_inst      = r_ic_inst;
  assign if_to_mc_req       = r_mc_req;
  assign if_to_mc_addr      = r_mc_addr;
  assign if_to_iq_valid     = r_iq_valid && rdy_in;
  assign if_to_iq_inst      = r_iq_inst;
  assign if_to_iq_pc        = r_iq_pc;

  always_comb begin
    w_state_next = r_state;
    w_hit_go     = 1'b0;
    w_miss_go    = 1'b0;
    w_done_go    = 1'b0;
    if (rdy_in) begin
      if (clr_in) begin
        w_state_next = LOOKUP;
      end else begin
        case (r_state)
          LOOKUP: begin
            if (w_lookup_go) begin
              if (w_hit) begin
                w_hit_go = 1'b1;
              end else begin
                w_miss_go    = 1'b1;
                w_state_next = MEM_WAIT;
              end
            end
          end
          MEM_WAIT: begin
            if (mc_to_if_done) begin
              w_done_go = 1'b1;
`ifdef IFETCH_ICACHE_EN
              w_state_next = FILL;
`else
              w_state_next = LOOKUP;
`endif
            end
          end
          default: w_state_next = LOOKUP;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state    <= LOOKUP;
      r_pc       <= RESET_PC;
      r_mc_addr  <= 32'h0;
      r_mc_req   <= 1'b0;
      r_iq_valid <= 1'b0;
      r_iq_inst  <= 32'h0;
      r_iq_pc    <= 32'h0;
      r_ic_inst  <= 32'h0;
    end else if (rdy_in) begin
      r_state    <= w_state_next;
      r_iq_valid <= w_hit_go || w_done_go;
      if (clr_in) begin
        r_pc     <= clr_pc;
        r_mc_req <= 1'b0;
      end
      if (w_hit_go) begin
        r_iq_inst <= ic_to_if_hit_inst;
        r_iq_pc   <= r_pc;
        r_pc      <= r_pc + 32'd4;
      end
      if (w_miss_go) begin
        r_mc_req  <= 1'b1;
        r_mc_addr <= r_pc;
      end
      if (w_done_go) begin
        r_mc_req  <= 1'b0;
        r_iq_inst <= mc_to_if_inst;
        r_iq_pc   <= r_mc_addr;
        r_pc      <= r_pc + 32'd4;
        r_ic_inst <= mc_to_if_inst;
      end
    end
  end

`ifdef IFETCH_ICACHE_EN
  // Fill strobe is raised only on the MEM_WAIT->FILL transition and drops on the next enabled cycle.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_ic_valid <= 1'b0;
    end else if (rdy_in) begin
      r_ic_valid <= w_done_go;
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetcher.sv
// Randomized bench for inst_fetcher: transaction-level model of pc flow, memory responder and cache model.
module tb_inst_fetcher;

`ifdef IFETCH_ICACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clr_in;
  logic [31:0] clr_pc;
  logic [31:0] if_to_ic_inst_addr, if_to_ic_inst;
  logic        if_to_ic_inst_valid, if_to_ic_ready;
  logic        ic_to_if_hit;
  logic [31:0] ic_to_if_hit_inst;
  logic        if_to_mc_req;
  logic [31:0] if_to_mc_addr;
  logic        mc_to_if_done;
  logic [31:0] mc_to_if_inst;
  logic        if_to_iq_valid;
  logic [31:0] if_to_iq_inst, if_to_iq_pc;
  logic        iq_to_if_full;

  inst_fetcher #(.RESET_PC(32'h0)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clr_in(clr_in), .clr_pc(clr_pc),
    .if_to_ic_inst_addr(if_to_ic_inst_addr), .if_to_ic_inst(if_to_ic_inst),
    .if_to_ic_inst_valid(if_to_ic_inst_valid), .if_to_ic_ready(if_to_ic_ready),
    .ic_to_if_hit(ic_to_if_hit), .ic_to_if_hit_inst(ic_to_if_hit_inst),
    .if_to_mc_req(if_to_mc_req), .if_to_mc_addr(if_to_mc_addr),
    .mc_to_if_done(mc_to_if_done), .mc_to_if_inst(mc_to_if_inst),
    .if_to_iq_valid(if_to_iq_valid), .if_to_iq_inst(if_to_iq_inst), .if_to_iq_pc(if_to_iq_pc),
    .iq_to_if_full(iq_to_if_full)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_fail   = 0;
  int n_issue  = 0;

  // Reference model: fetch pc, what the fetcher is waiting on, and the issue/fill it owes.
  logic [31:0] m_pc, m_fetch, m_iss_pc, m_iss_inst, m_fill_inst, last_iss_pc;
  int          m_phase;   // 0 looking up, 1 waiting on memory, 2 filling the cache
  bit          m_iss_pend;
  bit          wrap_ok;
  int          mem_cnt, mem_lat;
  bit          cached [logic [31:0]];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h00000013;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst_in = 1'b1; rdy_in = 1'b1; clr_in = 1'b1; clr_pc = 32'h55;
    iq_to_if_full = 1'b0; mc_to_if_done = 1'b1; mc_to_if_inst = 32'hDEAD;
    ic_to_if_hit = 1'b1; ic_to_if_hit_inst = 32'hBEEF;
    repeat (2) @(negedge clk_in);
    check("rst_iq_valid", if_to_iq_valid, 0);
    check("rst_iq_inst", if_to_iq_inst, 0);
    check("rst_iq_pc", if_to_iq_pc, 0);
    check("rst_mc_req", if_to_mc_req, 0);
    check("rst_mc_addr", if_to_mc_addr, 0);
    check("rst_fill_valid", if_to_ic_inst_valid, 0);
    check("rst_fill_inst", if_to_ic_inst, 0);
    check("rst_pc", if_to_ic_inst_addr, 32'h0);
    rst_in = 1'b0;
    m_pc = 32'h0; m_phase = 0; m_iss_pend = 1'b0;
    mem_cnt = 0; mem_lat = 3;
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic step(input bit rdy, input bit clr, input logic [31:0] cpc, input bit full,
                      input bit force_done);
    bit hit, done, exp_iss, exp_fill;
    logic [31:0] a;
    a    = if_to_ic_inst_addr;
    hit  = CACHE ? cached.exists(a) != 0 : ($urandom_range(0, 1) == 1);
    done = if_to_mc_req && (force_done || mem_cnt >= mem_lat);
    rdy_in = rdy; clr_in = clr; clr_pc = cpc; iq_to_if_full = full;
    ic_to_if_hit = hit; ic_to_if_hit_inst = mem_word(a);
    mc_to_if_done = done;
    mc_to_if_inst = done ? mem_word(if_to_mc_addr) : $urandom;
    #1;
    exp_iss = rdy && m_iss_pend;
    check("iq_valid", if_to_iq_valid, exp_iss);
    if (exp_iss) begin
      check("iq_pc", if_to_iq_pc, m_iss_pc);
      check("iq_inst", if_to_iq_inst, m_iss_inst);
      $display("issue pc=%h inst=%h", if_to_iq_pc, if_to_iq_inst);
      if (last_iss_pc == 32'hFFFFFFFC && if_to_iq_pc == 32'h0) wrap_ok = 1'b1;
      last_iss_pc = if_to_iq_pc;
      n_issue++;
    end
    check("mc_req", if_to_mc_req, m_phase == 1);
    if (m_phase == 1) check("mc_addr", if_to_mc_addr, m_fetch);
    check("ic_addr", if_to_ic_inst_addr, (m_phase == 0) ? m_pc : m_fetch);
    check("ic_ready", if_to_ic_ready, CACHE && m_phase == 0 && rdy && !full && !clr);
    exp_fill = CACHE && m_phase == 2 && rdy && !clr;
    check("fill_valid", if_to_ic_inst_valid, exp_fill);
    if (exp_fill) check("fill_inst", if_to_ic_inst, m_fill_inst);
    if (if_to_ic_inst_valid) cached[if_to_ic_inst_addr] = 1'b1;
    if (rdy) begin
      m_iss_pend = 1'b0;
      if (clr) begin
        m_pc = cpc; m_phase = 0;
      end else begin
        case (m_phase)
          0: if (!full) begin
            if (CACHE && hit) begin
              m_iss_pend = 1'b1; m_iss_pc = m_pc; m_iss_inst = mem_word(m_pc);
              m_pc = m_pc + 32'd4;
            end else begin
              m_fetch = m_pc; m_phase = 1;
            end
          end
          1: if (done) begin
            m_iss_pend = 1'b1; m_iss_pc = m_fetch; m_iss_inst = mem_word(m_fetch);
            m_fill_inst = mem_word(m_fetch);
            m_pc = m_pc + 32'd4;
            m_phase = CACHE ? 2 : 0;
          end
          default: m_phase = 0;
        endcase
      end
    end
    if (done) begin
      mem_cnt = 0; mem_lat = $urandom_range(1, 4);
    end else if (if_to_mc_req) mem_cnt++;
    else mem_cnt = 0;
    @(negedge clk_in);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic wait_memwait(input string tag);
    for (int i = 0; i < 20 && m_phase != 1; i++) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    check(tag, m_phase == 1, 1);
  endtask

  initial begin
    last_iss_pc = 32'h0; wrap_ok = 1'b0;
    for (int i = 0; i < 4; i++) cached[32'h100 + 32'(i * 4)] = 1'b1;
    for (int i = 0; i < 40; i++) cached[32'($urandom_range(0, 255)) << 2] = 1'b1;
    cached.delete(32'h0);
    cached.delete(32'h40);
    cached.delete(32'h80);
    cached.delete(32'h200);
    cached.delete(32'h500);
    cached.delete(32'h600);
    @(negedge clk_in);
    do_reset();
    // Cold start at 0 with a 3-cycle memory.
    run(14);
    // Preloaded hits from 0x100.
    step(1'b1, 1'b1, 32'h100, 1'b0, 1'b0);
    run(8);
    // Redirect during a memory wait.
    step(1'b1, 1'b1, 32'h40, 1'b0, 1'b0);
    wait_memwait("reach_mw_40");
    step(1'b1, 1'b1, 32'h200, 1'b0, 1'b0);
    run(8);
    // Redirect coincident with memory done.
    step(1'b1, 1'b1, 32'h80, 1'b0, 1'b0);
    wait_memwait("reach_mw_80");
    step(1'b1, 1'b1, 32'h300, 1'b0, 1'b1);
    run(3);
    // Queue full for five cycles.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    run(8);
    // Enable low for four cycles mid memory wait, with done offered.
    step(1'b1, 1'b1, 32'h500, 1'b0, 1'b0);
    wait_memwait("reach_mw_500");
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    run(10);
    // pc wrap-around.
    step(1'b1, 1'b1, 32'hFFFFFFF0, 1'b0, 1'b0);
    run(40);
    check("pc_wrap", wrap_ok, 1);
    // Reset aborts an in-flight fetch.
    step(1'b1, 1'b1, 32'h600, 1'b0, 1'b0);
    wait_memwait("reach_mw_600");
    @(negedge clk_in);
    do_reset();
    run(10);
    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 9) != 0, $urandom_range(0, 32) == 0,
           32'($urandom_range(0, 255)) << 2, $urandom_range(0, 4) == 0, 1'b0);
    end
    check("issue_count_min", n_issue > 100, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_fetcher.md
INST_FETCHER -- requirements
Module: inst_fetcher

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0, the PC loaded at reset.
REQ-002 SHALL have clk_in  in  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have rst_in  in  1  reset, synchronous and active-high.
REQ-004 SHALL have rdy_in  in  1  global enable; low freezes all state.
REQ-005 SHALL have clr_in  in  1  flush/redirect request; clr_pc  in  32  redirect target.
REQ-006 SHALL have if_to_ic_inst_addr  out  32  lookup/fill address; if_to_ic_inst  out  32  fill data; if_to_ic_inst_valid  out  1  fill strobe; if_to_ic_ready  out  1  lookup enable.
REQ-007 SHALL have ic_to_if_hit  in  1  cache hit; ic_to_if_hit_inst  in  32  hit data (both combinational from cache).
REQ-008 SHALL have if_to_mc_req  out  1  memory fetch request; if_to_mc_addr  out  32  fetch address; mc_to_if_done  in  1  fetch complete pulse; mc_to_if_inst  in  32  fetched word.
REQ-009 SHALL have if_to_iq_valid  out  1  issue pulse; if_to_iq_inst  out  32; if_to_iq_pc  out  32; iq_to_if_full  in  1  queue cannot take another entry.

Function
REQ-010 SHALL implement FSM states LOOKUP, MEM_WAIT, FILL.
REQ-011 SHALL drive if_to_ic_ready = (state==LOOKUP) && rdy_in && !iq_to_if_full && !clr_in, combinationally.
REQ-012 SHALL drive if_to_ic_inst_addr = pc in LOOKUP, = latched fetch address in MEM_WAIT/FILL.
REQ-013 LOOKUP with if_to_ic_ready && ic_to_if_hit: next cycle if_to_iq_valid=1, if_to_iq_inst=hit data, if_to_iq_pc=pc; pc<=pc+4 (mod 2^32); stay LOOKUP; one issue per cycle sustained.
REQ-014 LOOKUP with if_to_ic_ready && !ic_to_if_hit: next cycle if_to_mc_req=1, if_to_mc_addr=pc; go MEM_WAIT.
REQ-015 MEM_WAIT: hold if_to_mc_req and address stable until mc_to_if_done; on done: drop req, issue word to queue next cycle (valid, inst, pc=fetch address), pc<=pc+4, latch word, go FILL.
REQ-016 FILL: exactly one cycle with if_to_ic_inst_valid=1, if_to_ic_inst=latched word, address=fetch address, if_to_ic_ready=0; then LOOKUP.
REQ-017 if_to_iq_valid and if_to_ic_inst_valid SHALL be single-cycle pulses; 0 in all other cycles.
REQ-018 iq_to_if_full high: no new lookup or memory request starts; an in-flight MEM_WAIT completes and issues (queue reserves one slot).
REQ-019 clr_in high (rdy_in high), any state: pc<=clr_pc, state<=LOOKUP, if_to_mc_req<=0, no issue next cycle; clr_in has priority over hit, done and fill.
REQ-020 clr_in coincident with mc_to_if_done: word discarded, not issued, not filled.
REQ-021 rdy_in low: all registers hold; pulse outputs forced 0; if_to_mc_req holds value.
REQ-022 pc wrap: 32'hFFFFFFFC+4 SHALL yield 32'h0.

Reset
REQ-023 On rst_in: pc=RESET_PC, state=LOOKUP, if_to_mc_req=0, if_to_mc_addr=0, if_to_iq_valid=0, if_to_iq_inst=0, if_to_iq_pc=0, if_to_ic_inst_valid=0, if_to_ic_inst=0.
REQ-024 Reset SHALL override rdy_in and clr_in and abort any in-flight fetch.

Configuration
REQ-025 Macro IFETCH_ICACHE_EN defined: behaviour per REQ-010..022.
REQ-026 Macro undefined: if_to_ic_ready and if_to_ic_inst_valid tied 0, FILL state absent (MEM_WAIT returns directly to LOOKUP), every fetch takes the memory path; lookup-issue timing otherwise identical.

Verification
REQ-027 Reset, RESET_PC=0, cache cold, memory returns 32'h00000013 for addr 0 after 3 cycles -> req at addr 0, issue inst 32'h13 pc 0, fill pulse addr 0, next request addr 4.
REQ-028 Preloaded hits at 0x100..0x10C -> four consecutive issue pulses, pcs 0x100,0x104,0x108,0x10C, no mc request.
REQ-029 clr_in with clr_pc=0x200 during MEM_WAIT for 0x40 -> req drops next cycle, no issue of 0x40, next request addr 0x200.
REQ-030 clr_in coincident with done -> no issue, no fill pulse, pc=clr_pc.
REQ-031 iq_to_if_full high for 5 cycles in LOOKUP -> if_to_ic_ready=0, no req, no issue; resumes at same pc after release.
REQ-032 rdy_in low 4 cycles mid MEM_WAIT -> req/address held, done ignored-free; completes normally after rdy_in returns.
